// File: rtl/sar_hex_search_pkg.sv
// Shared types and defaults for the successive-approximation search controller.
// Imported by sar_hex_search and anything that instantiates it.
package sar_hex_search_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      TRY  = 1'b1
   } state_t;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/sar_hex_search.sv
// MSB-first binary search against an external magnitude comparator.
// One trial per SETTLE cycles, early exit on EQ, start/busy/done handshake.
module sar_hex_search
   import sar_hex_search_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   input  logic             cmp_eq,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);

   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH - 1);
   localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_TOP = CW'(SETTLE - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [IDXW-1:0]  idx_reg, idx_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] probe_reg, probe_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             found_reg, found_next;
   logic             err_reg, err_next;

   logic [WIDTH-1:0] acc_new;
   logic             flags_onehot;

   // Odd number of flags set, but not all three: exactly one.
   assign flags_onehot = (cmp_gt ^ cmp_lt ^ cmp_eq) & ~(cmp_gt & cmp_lt & cmp_eq);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         acc_reg    <= '0;
         idx_reg    <= '0;
         cnt_reg    <= '0;
         probe_reg  <= '0;
         result_reg <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         found_reg  <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         idx_reg    <= idx_next;
         cnt_reg    <= cnt_next;
         probe_reg  <= probe_next;
         result_reg <= result_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
         found_reg  <= found_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      idx_next    = idx_reg;
      cnt_next    = cnt_reg;
      probe_next  = probe_reg;
      result_next = result_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      found_next  = found_reg;
      err_next    = err_reg;
      acc_new     = cmp_gt ? probe_reg : acc_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               acc_next   = '0;
               idx_next   = IDX_TOP;
               probe_next = MSB;
               cnt_next   = CNT_TOP;
               busy_next  = 1'b1;
               found_next = 1'b0;
               err_next   = 1'b0;
               state_next = TRY;
            end
         end

         TRY: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - CW'(1);
            end else if (!flags_onehot) begin
               err_next    = 1'b1;
               result_next = probe_reg;
               done_next   = 1'b1;
               busy_next   = 1'b0;
               state_next  = IDLE;
            end else if (cmp_eq) begin
               found_next  = 1'b1;
               result_next = probe_reg;
               done_next   = 1'b1;
               busy_next   = 1'b0;
               state_next  = IDLE;
            end else if (idx_reg == '0) begin
               // Every bit dropped without EQ: only a zero unknown lands here.
               acc_next    = acc_new;
               result_next = acc_new;
               found_next  = 1'b0;
               done_next   = 1'b1;
               busy_next   = 1'b0;
               state_next  = IDLE;
            end else begin
               acc_next   = acc_new;
               idx_next   = idx_reg - IDXW'(1);
               probe_next = acc_new | (ONE << (idx_reg - IDXW'(1)));
               cnt_next   = CNT_TOP;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign probe  = probe_reg;
   assign busy   = busy_reg;
   assign done   = done_reg;
   assign result = result_reg;
   assign found  = found_reg;
   assign err    = err_reg;

endmodule
